// File: rtl/fp_div_arbiter.sv
// Two-requester round-robin front end for one shared combinational
// IEEE-754 double-precision divider. A granted request's operands are
// captured into local registers. The divider output is given LATENCY cycles
// to settle as a multicycle path. It is then captured and held until the
// consumer accepts it.

module double_precision_fp_divider_combinational (
    input  logic [63:0] input_a,
    input  logic [63:0] input_b,
    output logic [63:0] output_z
);

    // Correctly rounded (round-to-nearest-even) a / b, including subnormals.
    function automatic logic [63:0] fp_div(input logic [63:0] a, input logic [63:0] b);
        logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sign;
        logic [52:0] ma, mb;
        logic [54:0] rem;
        logic [54:0] q;
        logic [55:0] v;
        logic [62:0] mag;
        logic        round_up;
        int          ea, eb, e, sh;
        logic [63:0] z;

        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
        a_zero = (a[62:52] == 11'h000) && (a[51:0] == 52'd0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
        b_zero = (b[62:52] == 11'h000) && (b[51:0] == 52'd0);
        sign   = a[63] ^ b[63];

        // Unpack with the hidden bit; subnormals get exponent 1 and are
        // then normalised so the leading one sits at bit 52.
        ma = (a[62:52] == 11'h000) ? {1'b0, a[51:0]} : {1'b1, a[51:0]};
        mb = (b[62:52] == 11'h000) ? {1'b0, b[51:0]} : {1'b1, b[51:0]};
        ea = (a[62:52] == 11'h000) ? 1 : int'(a[62:52]);
        eb = (b[62:52] == 11'h000) ? 1 : int'(b[62:52]);
        for (int i = 0; i < 52; i++) begin
            if (!ma[52]) begin
                ma = ma << 1;
                ea = ea - 1;
            end
            if (!mb[52]) begin
                mb = mb << 1;
                eb = eb - 1;
            end
        end

        // Pre-scale the dividend so the quotient lies in [1, 2).
        e = ea - eb + 1023;
        if (ma < mb) begin
            rem = {1'b0, ma, 1'b0};
            e   = e - 1;
        end else begin
            rem = {2'b00, ma};
        end

        // Restoring division: 1 integer bit, 52 fraction bits, 2 extra bits.
        q = '0;
        for (int i = 54; i >= 0; i--) begin
            if (rem >= {2'b00, mb}) begin
                q[i] = 1'b1;
                rem  = rem - {2'b00, mb};
            end
            rem = rem << 1;
        end
        v = {q, |rem};

        // Gradual underflow: shift right and keep the lost bits in v[0].
        sh = (e < 1) ? (1 - e) : 0;
        for (int i = 0; i < 56; i++) begin
            if (i < sh) begin
                v = {1'b0, v[55:1]} | {55'd0, v[0]};
            end
        end
        if (e < 1) begin
            e = 0;
        end

        // Adding into the packed exponent:fraction handles a carry from
        // subnormal to normal and from the largest finite value to infinity.
        round_up = v[2] & (v[3] | v[1] | v[0]);
        mag      = {e[10:0], v[54:3]} + {62'd0, round_up};

        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            z = 64'h7FF8_0000_0000_0000;
        end else if (a_inf || b_zero) begin
            z = {sign, 11'h7FF, 52'd0};
        end else if (a_zero || b_inf) begin
            z = {sign, 63'd0};
        end else if (e >= 2047) begin
            z = {sign, 11'h7FF, 52'd0};
        end else begin
            z = {sign, mag};
        end
        return z;
    endfunction

    assign output_z = fp_div(input_a, input_b);

endmodule

module fp_div_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [63:0] out_z,
    output logic        out_id,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_count;
    logic [63:0] r_op_a;
    logic [63:0] r_op_b;
    logic        r_op_id;
    logic        r_last_id;
    logic [63:0] r_out_z;
    logic        r_out_id;
    logic [63:0] w_div_z;
    logic        w_grant0;
    logic        w_grant1;

    double_precision_fp_divider_combinational u_div (
        .input_a  (r_op_a),
        .input_b  (r_op_b),
        .output_z (w_div_z)
    );

    // Round-robin pick in IDLE: on contention favour whoever was not granted last.
    assign w_grant0 = (r_state == IDLE) && req0_valid && (!req1_valid || r_last_id);
    assign w_grant1 = (r_state == IDLE) && req1_valid && (!req0_valid || !r_last_id);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so no path leaves w_next_state
        // unassigned and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant0 || w_grant1) w_next_state = CALC;
            CALC:    if (r_count == 4'd0)      w_next_state = DONE;
            DONE:    if (out_ready)            w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state; ready is withheld during reset.
    always_comb begin
        req0_ready = rst_n && w_grant0;
        req1_ready = rst_n && w_grant1;
        out_valid  = (r_state == DONE);
        busy       = (r_state != IDLE);
    end

    // Datapath: latch operands on grant, count down the settle time, capture result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= 4'd0;
            r_op_a    <= 64'd0;
            r_op_b    <= 64'd0;
            r_op_id   <= 1'b0;
            r_last_id <= 1'b1;
            r_out_z   <= 64'd0;
            r_out_id  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_op_a    <= w_grant1 ? req1_a : req0_a;
                        r_op_b    <= w_grant1 ? req1_b : req0_b;
                        r_op_id   <= w_grant1;
                        r_last_id <= w_grant1;
                        r_count   <= COUNT_INIT;
                    end
                end
                CALC: begin
                    if (r_count == 4'd0) begin
                        r_out_z  <= w_div_z;
                        r_out_id <= r_op_id;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_z  = r_out_z;
    assign out_id = r_out_id;

endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the cycles the shared divider result settles before capture (multicycle path); legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; it SHALL be synchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has operands.
REQ-005 req0_a, req0_b  input  64 each  requester 0 dividend and divisor, IEEE-754 double.
REQ-006 req0_ready  output  1  operands of requester 0 accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  SHALL mirror REQ-004..006 for requester 1.
REQ-008 out_valid  output  1  result available.
REQ-009 out_z  output  64  quotient from the shared divider.
REQ-010 out_id  output  1  requester index that owns out_z.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL instantiate one double_precision_fp_divider_combinational and drive its input_a/input_b only from internal operand registers.
REQ-014 FSM states SHALL be IDLE, CALC, DONE.
REQ-015 In IDLE with at least one valid request, the arbiter SHALL grant exactly one requester, pulse its ready for one cycle, latch its a/b and index, load count = LATENCY-1, and go to CALC.
REQ-016 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-017 A single valid request SHALL be granted regardless of priority.
REQ-018 The req*_ready outputs SHALL be combinational and asserted only in IDLE: at most one is high, and never both.
REQ-019 In CALC, count SHALL decrement each cycle; when count is 0, out_z SHALL register the divider output, out_id SHALL register the latched index, and the FSM SHALL move to DONE.
REQ-020 Grant-to-out_valid latency SHALL be exactly LATENCY+1 cycles.
REQ-021 In DONE, out_valid SHALL be 1, and out_z and out_id SHALL hold stable until out_valid && out_ready.
REQ-022 On that handshake the FSM SHALL return to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-023 Operand registers SHALL not change outside the IDLE grant cycle; requester input changes during CALC/DONE SHALL have no effect.
REQ-024 Requests pending during CALC/DONE SHALL be held off (ready 0) and SHALL not be dropped; the requester keeps valid asserted.
REQ-025 Special-case encodings (NaN, zero, infinity) SHALL pass through from the divider unmodified; the block SHALL perform no arithmetic itself.
REQ-026 out_valid SHALL never assert without a prior grant.

Reset
REQ-027 While rst_n is 0 at a clock edge, the next state SHALL be: state IDLE, out_valid 0, out_z 0, out_id 0, busy 0, count 0, operand registers 0, last-grant pointer favouring requester 0.
REQ-028 req*_ready SHALL be 0 while rst_n is 0.
REQ-029 Reset asserted mid-CALC or mid-DONE SHALL abort the operation: no out_valid afterwards for the aborted request.

Verification
REQ-030 Single request: req0 with a=0x7FF8000000000000, b=0x3FF0000000000000, LATENCY=4 -> req0_ready pulses at T, out_valid at T+5 with out_z=0x7FF8000000000000, out_id=0.
REQ-031 Simultaneous requests after reset: req0 a=0, b=0x3FF0000000000000; req1 a=0x7FF0000000000000, b=0x4000000000000000 -> first result out_id=0 with out_z=0; second result out_id=1 with out_z=0x7FF0000000000000.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_z stable, both ready 0, busy 1; after out_ready=1, IDLE on the next cycle.
REQ-033 Fairness: both requesters valid continuously for 8 grants -> out_id sequence 0,1,0,1,0,1,0,1.
REQ-034 Reset mid-CALC: deassert rst_n 2 cycles after grant -> out_valid 0, busy 0; the next grant goes to requester 0 if both are valid.
REQ-035 Operand stability: change req0_a during CALC -> out_z reflects the operands latched at grant.
